// File: rtl/mem_access_ctrl.sv
// Load/store unit bridging the execute stage to a valid/ready data memory (RV32 byte/half/word).
// Build option: define MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqIsStore,
    input  logic [2:0]  ReqFunct,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        MemReqValid,
    input  logic        MemReqReady,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemWe,
    output logic [31:0] MemWData,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic [2:0]  RespFunct,
    output logic        Stall,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct_q, funct_d;
    logic        store_q, store_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        misalign_q, misalign_d;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

`ifdef MISALIGN_SPLIT_EN
    function automatic logic crosses_word(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   crosses_word = 1'b0;
            2'b01:   crosses_word = (off == 2'd3);
            default: crosses_word = (off != 2'd0);
        endcase
    endfunction
`else
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'd0);
        endcase
    endfunction
`endif

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [7:0]  mask8;
    logic [63:0] wd64;
    logic [63:0] ld64;
    logic [31:0] ld_word;
    logic [31:0] ld_data;
    logic        crossing;
    logic        req_misalign;
    logic        issue;

    assign off  = addr_q[1:0];
    assign sh   = {off, 3'b000};
    // Both lane masks and lane data are formed as one double-word so the
    // phase-1 half is simply the spill-over of the phase-0 shift.
    assign mask8 = {4'b0000, size_mask(funct_q[1:0])} << off;
    assign wd64  = {32'd0, wdata_q} << sh;

`ifdef MISALIGN_SPLIT_EN
    assign crossing     = crosses_word(funct_q[1:0], off);
    assign req_misalign = 1'b0;
`else
    assign crossing     = 1'b0;
    assign req_misalign = is_misaligned(ReqFunct[1:0], ReqAddr[1:0]);
`endif

    assign ld64    = phase_q ? {MemRespData, rdata0_q} : {32'd0, MemRespData};
    assign ld_word = 32'(ld64 >> sh);

    always_comb begin
        case (funct_q[1:0])
            2'b00:   ld_data = {24'd0, ld_word[7:0]};
            2'b01:   ld_data = {16'd0, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    assign issue       = (state_q == ISSUE);
    assign ReqReady    = (state_q == IDLE);
    assign Stall       = ~ReqReady;
    assign MemReqValid = issue;
    assign MemAddr     = issue ? ({addr_q[31:2], 2'b00} + {29'd0, phase_q, 2'b00}) : '0;
    assign MemWe       = (issue && store_q) ? (phase_q ? mask8[7:4] : mask8[3:0]) : '0;
    assign MemWData    = (issue && store_q) ? (phase_q ? wd64[63:32] : wd64[31:0]) : '0;
    assign RespValid   = resp_valid_q;
    assign RespData    = resp_data_q;
    assign RespFunct   = funct_q;
    assign MisalignErr = misalign_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct_d      = funct_q;
        store_d      = store_q;
        rdata0_d     = rdata0_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        misalign_d   = misalign_q;

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    funct_d = ReqFunct;
                    store_d = ReqIsStore;
                    phase_d = 1'b0;
                    if (req_misalign) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        misalign_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (MemReqReady) begin
                    if (!store_q) begin
                        state_d = WAIT;
                    end else if (crossing && !phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        misalign_d   = 1'b0;
                        phase_d      = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            WAIT: begin
                if (MemRespValid) begin
                    if (crossing && !phase_q) begin
                        rdata0_d = MemRespData;
                        phase_d  = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = ld_data;
                        misalign_d   = 1'b0;
                        phase_d      = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct_q      <= '0;
            store_q      <= 1'b0;
            rdata0_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct_q      <= funct_d;
            store_q      <= store_d;
            rdata0_q     <= rdata0_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            misalign_q   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: vector table plus stall, reset and back-to-back sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ReqValid, ReqReady, ReqIsStore;
    logic [2:0]  ReqFunct;
    logic [31:0] ReqAddr, ReqWData;
    logic        MemReqValid, MemReqReady;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemWe;
    logic        MemRespValid;
    logic [31:0] MemRespData;
    logic        RespValid;
    logic [31:0] RespData;
    logic [2:0]  RespFunct;
    logic        Stall, MisalignErr;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqIsStore(ReqIsStore),
        .ReqFunct(ReqFunct), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
        .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .RespValid(RespValid), .RespData(RespData), .RespFunct(RespFunct),
        .Stall(Stall), .MisalignErr(MisalignErr)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_hs   = 0;
    int exp_hs = 0;

    always @(posedge clk)
        if (MemReqValid && MemReqReady) n_hs++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_resp;
        logic        e_err;
    } vec_t;

    vec_t tbl[16];
    int   n_vec = 0;

    task automatic add_vec(input logic st, input logic [2:0] f, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input logic [31:0] e_addr, input logic [3:0] e_we,
                           input logic [31:0] e_wdata, input logic [31:0] e_resp,
                           input logic e_err);
        tbl[n_vec] = '{st, f, addr, wdata, word, e_addr, e_we, e_wdata, e_resp, e_err};
        n_vec++;
    endtask

    task automatic run_vec(input vec_t v);
        ReqValid   = 1'b1;
        ReqIsStore = v.st;
        ReqFunct   = v.f;
        ReqAddr    = v.addr;
        ReqWData   = v.wdata;
        chk("ReqReady_before", ReqReady, 1);
        cyc();
        ReqValid = 1'b0;
        if (v.e_err) begin
            chk("err_RespValid", RespValid, 1);
            chk("err_MisalignErr", MisalignErr, 1);
            chk("err_RespData", RespData, 0);
            chk("err_MemReqValid", MemReqValid, 0);
        end else begin
            exp_hs++;
            chk("MemReqValid", MemReqValid, 1);
            chk("MemAddr", MemAddr, v.e_addr);
            chk("MemWe", MemWe, v.e_we);
            if (v.st) chk("MemWData", MemWData, v.e_wdata);
            chk("Stall_issue", Stall, 1);
            MemReqReady = 1'b1;
            cyc();
            MemReqReady = 1'b0;
            if (!v.st) begin
                chk("wait_RespValid", RespValid, 0);
                chk("wait_MemReqValid", MemReqValid, 0);
                MemRespValid = 1'b1;
                MemRespData  = v.word;
                cyc();
                MemRespValid = 1'b0;
                chk("RespData", RespData, v.e_resp);
            end
            chk("RespValid", RespValid, 1);
            chk("RespFunct", RespFunct, v.f);
            chk("MisalignErr", MisalignErr, 0);
            chk("ReqReady_done", ReqReady, 1);
        end
        cyc();
        chk("RespValid_pulse", RespValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ReqValid = 0; ReqIsStore = 0; ReqFunct = 0; ReqAddr = 0; ReqWData = 0;
        MemReqReady = 0; MemRespValid = 0; MemRespData = 0;

        //       st  f       addr          wdata         word          e_addr        e_we     e_wdata       e_resp        err
        add_vec(0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF, 0);
        add_vec(1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,       32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0,        0);
        add_vec(1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,       32'h0000_0100, 4'b1100, 32'hBEEF_0000, 32'h0,        0);
        add_vec(1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h0,       32'h0000_0104, 4'b1111, 32'h1234_5678, 32'h0,        0);
        add_vec(1, 3'b000, 32'h0000_0200, 32'hFFFF_FF5A, 32'h0,       32'h0000_0200, 4'b0001, 32'hFFFF_FF5A, 32'h0,        0);
        add_vec(0, 3'b000, 32'h0000_0101, 32'h0,        32'h1122_3344, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0033, 0);
        add_vec(0, 3'b101, 32'h0000_0102, 32'h0,        32'h8899_AABB, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8899, 0);
        add_vec(0, 3'b100, 32'h0000_0103, 32'h0,        32'hF000_0000, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00F0, 0);
        add_vec(0, 3'b001, 32'h0000_0200, 32'h0,        32'h1234_8765, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_8765, 0);
`ifdef MISALIGN_SPLIT_EN
        add_vec(1, 3'b001, 32'h0000_0201, 32'h0000_BEEF, 32'h0,       32'h0000_0200, 4'b0110, 32'h00BE_EF00, 32'h0,        0);
        add_vec(0, 3'b001, 32'h0000_0101, 32'h0,        32'h1122_3344, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_2233, 0);
`else
        add_vec(0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1);
        add_vec(0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1);
        add_vec(1, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1);
        add_vec(1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1);
        add_vec(0, 3'b101, 32'h0000_0103, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ReqReady", ReqReady, 1);
        chk("rst_Stall", Stall, 0);
        chk("rst_MemReqValid", MemReqValid, 0);
        chk("rst_MemAddr", MemAddr, 0);
        chk("rst_MemWe", MemWe, 0);
        chk("rst_MemWData", MemWData, 0);
        chk("rst_RespValid", RespValid, 0);
        chk("rst_RespData", RespData, 0);
        chk("rst_RespFunct", RespFunct, 0);
        chk("rst_MisalignErr", MisalignErr, 0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < n_vec; i++) run_vec(tbl[i]);

        // LBU with a 5-cycle memory stall; stray request and response are ignored
        ReqValid = 1; ReqIsStore = 0; ReqFunct = 3'b100; ReqAddr = 32'h102;
        cyc();
        ReqValid = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                ReqValid = 1; ReqIsStore = 1; ReqAddr = 32'h500;
                MemRespValid = 1; MemRespData = 32'hBAD0_BAD0;
            end
            if (i == 3) begin
                ReqValid = 0; MemRespValid = 0;
            end
            chk("stall_MemReqValid", MemReqValid, 1);
            chk("stall_MemAddr", MemAddr, 32'h100);
            chk("stall_MemWe", MemWe, 0);
            chk("stall_Stall", Stall, 1);
            chk("stall_ReqReady", ReqReady, 0);
            chk("stall_RespValid", RespValid, 0);
            cyc();
        end
        MemReqReady = 1;
        chk("stall_MemAddr_acc", MemAddr, 32'h100);
        cyc();
        MemReqReady = 0;
        exp_hs++;
        chk("stall_wait_Stall", Stall, 1);
        MemRespValid = 1; MemRespData = 32'h1122_3344;
        cyc();
        MemRespValid = 0;
        chk("stall_RespValid", RespValid, 1);
        chk("stall_RespData", RespData, 32'h22);
        chk("stall_RespFunct", RespFunct, 3'b100);
        chk("stall_Stall_done", Stall, 0);
        cyc();
        chk("stall_no_extra_req", MemReqValid, 0);

        // asynchronous reset while waiting for load data
        ReqValid = 1; ReqIsStore = 0; ReqFunct = 3'b010; ReqAddr = 32'h100;
        cyc();
        ReqValid = 0;
        MemReqReady = 1;
        cyc();
        MemReqReady = 0;
        exp_hs++;
        #2 rst_n = 0;
        #1;
        chk("arst_ReqReady", ReqReady, 1);
        chk("arst_Stall", Stall, 0);
        chk("arst_MemReqValid", MemReqValid, 0);
        cyc();
        rst_n = 1;
        MemRespValid = 1; MemRespData = 32'h5555_AAAA;
        cyc();
        MemRespValid = 0;
        chk("arst_late_RespValid", RespValid, 0);
        chk("arst_late_ReqReady", ReqReady, 1);
        chk("arst_late_MemReqValid", MemReqValid, 0);
        cyc();
        chk("arst_late_RespValid2", RespValid, 0);

        // back-to-back: next request presented in the completion cycle
        ReqValid = 1; ReqIsStore = 1; ReqFunct = 3'b010; ReqAddr = 32'h300; ReqWData = 32'hCAFE_F00D;
        cyc();
        ReqValid = 0;
        MemReqReady = 1;
        cyc();
        MemReqReady = 0;
        exp_hs++;
        chk("b2b_RespValid1", RespValid, 1);
        chk("b2b_ReqReady", ReqReady, 1);
        ReqValid = 1; ReqIsStore = 0; ReqFunct = 3'b010; ReqAddr = 32'h304;
        cyc();
        ReqValid = 0;
        chk("b2b_RespValid_gone", RespValid, 0);
        chk("b2b_MemReqValid", MemReqValid, 1);
        chk("b2b_MemAddr", MemAddr, 32'h304);
        chk("b2b_MemWe", MemWe, 0);
        MemReqReady = 1;
        cyc();
        MemReqReady = 0;
        exp_hs++;
        MemRespValid = 1; MemRespData = 32'h0BAD_C0DE;
        cyc();
        MemRespValid = 0;
        chk("b2b_RespValid2", RespValid, 1);
        chk("b2b_RespData", RespData, 32'h0BAD_C0DE);
        cyc();
        chk("b2b_idle_MemReqValid", MemReqValid, 0);
        chk("b2b_idle_RespValid", RespValid, 0);

`ifdef MISALIGN_SPLIT_EN
        // word-crossing load and store split over two transactions
        ReqValid = 1; ReqIsStore = 0; ReqFunct = 3'b010; ReqAddr = 32'h102;
        cyc();
        ReqValid = 0;
        chk("split_ld_addr0", MemAddr, 32'h100);
        MemReqReady = 1; cyc(); MemReqReady = 0;
        MemRespValid = 1; MemRespData = 32'h1122_3344; cyc(); MemRespValid = 0;
        chk("split_ld_mid_RespValid", RespValid, 0);
        chk("split_ld_MemReqValid1", MemReqValid, 1);
        chk("split_ld_addr1", MemAddr, 32'h104);
        MemReqReady = 1; cyc(); MemReqReady = 0;
        MemRespValid = 1; MemRespData = 32'h5566_7788; cyc(); MemRespValid = 0;
        chk("split_ld_RespValid", RespValid, 1);
        chk("split_ld_RespData", RespData, 32'h7788_1122);
        chk("split_ld_MisalignErr", MisalignErr, 0);
        cyc();
        ReqValid = 1; ReqIsStore = 1; ReqFunct = 3'b010; ReqAddr = 32'h103; ReqWData = 32'hAABB_CCDD;
        cyc();
        ReqValid = 0;
        chk("split_st_addr0", MemAddr, 32'h100);
        chk("split_st_we0", MemWe, 4'b1000);
        chk("split_st_wd0", MemWData, 32'hDD00_0000);
        MemReqReady = 1; cyc(); MemReqReady = 0;
        chk("split_st_mid_RespValid", RespValid, 0);
        chk("split_st_addr1", MemAddr, 32'h104);
        chk("split_st_we1", MemWe, 4'b0111);
        chk("split_st_wd1", MemWData, 32'h00AA_BBCC);
        MemReqReady = 1; cyc(); MemReqReady = 0;
        chk("split_st_RespValid", RespValid, 1);
        chk("split_st_MisalignErr", MisalignErr, 0);
        exp_hs += 4;
        cyc();
`endif

        chk("handshake_count", n_hs, exp_hs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ReqValid  in  1  execute stage presents a load/store.
REQ-005 ReqReady  out  1  unit accepts a request; high only in IDLE.
REQ-006 ReqIsStore  in  1  1 = store, 0 = load.
REQ-007 ReqFunct  in  3  RV32 funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-008 ReqAddr  in  32  byte address; ReqWData  in  32  store source (rs2).
REQ-009 MemReqValid  out  1; MemReqReady  in  1  valid/ready handshake to data memory.
REQ-010 MemAddr  out  32  word address, bits [1:0] = 0; MemWe  out  4  byte write mask, 0000 for reads; MemWData  out  32  lane-aligned store data.
REQ-011 MemRespValid  in  1; MemRespData  in  32  read-return word.
REQ-012 RespValid  out  1  one-cycle completion pulse; RespData  out  32  load bytes right-justified, unused upper bits 0, unextended; RespFunct  out  3  captured funct3 for the downstream sign/zero-extension stage.
REQ-013 Stall  out  1  = ~ReqReady; MisalignErr  out  1  valid with RespValid.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT, with a phase bit (0 = first word, 1 = second word).
REQ-015 IDLE: on ReqValid&ReqReady, the block SHALL register addr/data/funct/type and go to ISSUE in the next cycle; MemReqValid is first asserted that cycle.
REQ-016 ISSUE: MemReqValid, MemAddr, MemWe and MemWData SHALL be held stable until MemReqReady; on acceptance, a store completes that phase and a load goes to WAIT.
REQ-017 WAIT: the block SHALL capture MemRespData on MemRespValid; at most one memory transaction is outstanding.
REQ-018 Store mask: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111; MemWData = ReqWData << 8*addr[1:0].
REQ-019 Load: RespData = MemRespData >> 8*addr[1:0], masked to 8/16/32 bits by funct3.
REQ-020 Completion: RespValid SHALL pulse the cycle after the final accepted store or final MemRespValid, with FSM back in IDLE that same cycle; a new request can be accepted while RespValid is high.
REQ-021 Requests while not IDLE SHALL be ignored (ReqReady = 0); MemRespValid in IDLE or ISSUE SHALL be ignored.
REQ-022 Best case latency, accept to RespValid: store 2 cycles, load 3 cycles (ready and response each in the earliest cycle).

Reset
REQ-023 rst_n low SHALL force IDLE, phase 0, and all outputs to 0 except ReqReady = 1, immediately and independent of clk.
REQ-024 Reset mid-transaction SHALL abandon it with no RespValid; a late MemRespValid is ignored per REQ-021.

Configuration
REQ-025 Macro MISALIGN_SPLIT_EN undefined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no memory transaction and SHALL pulse RespValid with MisalignErr = 1 and RespData = 0 the cycle after acceptance.
REQ-026 MISALIGN_SPLIT_EN defined: an access within one word SHALL be done in one transaction; a word-crossing access SHALL use two transactions (phase 0 at addr&~3, phase 1 at (addr&~3)+4). The phase 0 mask covers the bytes from the offset up; the phase 1 mask covers the remaining low bytes. Phase 1 store data = ReqWData >> 8*(4-off); load data merges word1 << 8*(4-off). MisalignErr is never asserted.

Verification
REQ-027 LW addr 0x100, memory returns 0xDEADBEEF -> RespData 0xDEADBEEF, RespFunct 010, RespValid 3 cycles after accept with zero-wait memory.
REQ-028 SB addr 0x203, data 0x000000A5 -> MemAddr 0x200, MemWe 1000, MemWData 0xA5000000, RespValid 1 cycle after MemReqReady.
REQ-029 LBU addr 0x102, word 0x11223344, MemReqReady held low 5 cycles -> outputs stable during stall, RespData 0x00000022, Stall high until completion.
REQ-030 LW addr 0x102: macro off -> MisalignErr 1, no MemReqValid. Macro on, words 0x11223344 / 0x55667788 -> reads 0x100 then 0x104, RespData 0x77881122.
REQ-031 rst_n pulsed low while in WAIT, then MemRespValid arrives -> no RespValid, ReqReady 1, state IDLE.
REQ-032 Back-to-back: a second request presented in the RespValid cycle -> accepted that cycle, with no dropped or duplicated transaction.
